// File: rtl/seg7_pkg.sv
// Shared definitions for the 8-digit seven-segment scan display:
// active-low segment codes, all-dark constants, source-select encodings
// and the leading-zero mask helper used when SEG7_LEAD_ZERO_BLANK_EN is defined.
package seg7_pkg;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
    localparam logic [6:0] SEG_CODES [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    localparam logic [1:0] SRC_LED    = 2'd0;
    localparam logic [1:0] SRC_ALL    = 2'd1;
    localparam logic [1:0] SRC_BRANCH = 2'd2;
    localparam logic [1:0] SRC_JMP    = 2'd3;

    // Bit k set means digit k sits above the most significant nonzero
    // nibble and should stay dark. Digit 0 is never blanked.
    function automatic logic [7:0] lead_zero_mask(input logic [31:0] value);
        logic [7:0] mask;
        logic       seen;
        mask = 8'h00;
        seen = 1'b0;
        for (int k = 7; k >= 1; k--) begin
            if (value[4*k +: 4] != 4'h0) seen = 1'b1;
            mask[k] = ~seen;
        end
        return mask;
    endfunction

endpackage

// File: rtl/seg7_scan_display_hex.sv
// Combinational nibble to active-low seven-segment code lookup.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_CODES[i_nibble];

endmodule

// File: rtl/seg7_scan_display.sv
// Scans a frame-coherent snapshot of one of four 32-bit CPU values as
// 8 hex digits onto a common-anode seven-segment display.
// Optional build macro: SEG7_LEAD_ZERO_BLANK_EN (blank leading-zero digits).
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [1:0]  i_sel,
    input  logic [31:0] i_leddata,
    input  logic [31:0] i_count_all,
    input  logic [31:0] i_count_branch,
    input  logic [31:0] i_count_jmp,
    output logic [7:0]  o_an,
    output logic [7:0]  o_seg
);

    localparam int             PW        = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]  PRESC_MAX = PW'(SCAN_DIV - 1);

    logic [PW-1:0] r_presc;
    logic [2:0]    r_idx;
    logic [31:0]   r_frame;
    logic [1:0]    r_sel;
    logic [7:0]    r_an;
    logic [7:0]    r_seg;

    logic          w_tick;
    logic          w_frame_end;
    logic [31:0]   w_src;
    logic [3:0]    w_nibble;
    logic [6:0]    w_seg7;
    logic          w_dp_n;

    assign w_tick      = (r_presc == PRESC_MAX);
    assign w_frame_end = w_tick && (r_idx == 3'd7);
    assign w_nibble    = r_frame[{r_idx, 2'b00} +: 4];
    // The decimal point marks that a counter (not Leddata) is on display.
    assign w_dp_n      = !((r_idx == 3'd7) && (r_sel != SRC_LED));

    // Source mux feeding the frame snapshot.
    always_comb begin
        w_src = i_leddata;
        case (i_sel)
            SRC_LED:    w_src = i_leddata;
            SRC_ALL:    w_src = i_count_all;
            SRC_BRANCH: w_src = i_count_branch;
            SRC_JMP:    w_src = i_count_jmp;
            default:    w_src = i_leddata;
        endcase
    end

    hex_to_seg7 u_hex (
        .i_nibble (w_nibble),
        .o_seg    (w_seg7)
    );

    // Prescaler: one tick per digit slot.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_presc <= '0;
        else if (w_tick) r_presc <= '0;
        else r_presc <= r_presc + 1'b1;
    end

    // Digit index advances once per slot and wraps 7 -> 0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_idx <= 3'd0;
        else if (w_tick) r_idx <= r_idx + 3'd1;
    end

    // Snapshot data and its select only at the frame boundary so the
    // display never tears and the dp always matches the digits shown.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_frame <= 32'h0;
            r_sel   <= SRC_LED;
        end else if (w_frame_end) begin
            r_frame <= w_src;
            r_sel   <= i_sel;
        end
    end

`ifdef SEG7_LEAD_ZERO_BLANK_EN
    logic [7:0] r_blank;

    // Blank mask follows the snapshot; reset frame of 0 shows digit 0 only.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_blank <= lead_zero_mask(32'h0);
        else if (w_frame_end) r_blank <= lead_zero_mask(w_src);
    end

    // Registered anode/segment drive with leading-zero blanking.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_OFF;
        end else if (r_blank[r_idx]) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_OFF;
        end else begin
            r_an  <= ~(8'b1 << r_idx);
            r_seg <= {w_dp_n, w_seg7};
        end
    end
`else
    // Registered anode/segment drive; every digit always shown.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_OFF;
        end else begin
            r_an  <= ~(8'b1 << r_idx);
            r_seg <= {w_dp_n, w_seg7};
        end
    end
`endif

    assign o_an  = r_an;
    assign o_seg = r_seg;

endmodule
